rcc_sys_clk_sw_ctrl: RTL
========================

RCC_SYS_CLK_SW_CTRL -- requirements
Module: rcc_sys_clk_sw_ctrl

Interface
REQ-001 The block SHALL have parameter SETTLE_CYCLES, default 4, legal range 1..15: number of hsi_clk cycles allowed for the glitch-free switch to complete.
REQ-002 The block SHALL have these ports:
- hsi_clk  in  1  sole clock, always-on HSI.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- sw_req  in  2  requested source: 0=HSI, 1=CSI, 2=HSE, 3=PLL1_P.
- sw_wr  in  1  one-cycle pulse; SW register field written.
- src_rdy  in  4  ready flags {pll1,hse,csi,hsi}; bit index = source code.
- stop_exit  in  1  one-cycle pulse; system leaving Stop mode.
- stopwuck  in  1  Stop wake-up clock: 0=HSI, 1=CSI.
- css_fail  in  1  one-cycle pulse; HSE clock-security failure.
- sys_clk_sw  out  2  registered select driven to the system clock switch.
- sws  out  2  registered status: source in use.
- sw_busy  out  1  high while in SWITCH.
- sw_done  out  1  one-cycle pulse; software-requested switch completed.
- sw_err  out  1  one-cycle pulse; request rejected or aborted.

Function
REQ-003 The FSM SHALL have two states, IDLE and SWITCH; sw_busy SHALL equal (state==SWITCH).
REQ-004 Internal registers SHALL be: target[1:0], cnt[3:0], and the abort flag hw (set = current SWITCH was hardware-forced or reverted).
REQ-005 All outputs SHALL be registered, with no combinational input-to-output path.
REQ-006 Events evaluated at each edge SHALL be prioritised as follows:
- css_fail
- stop_exit
- target not ready (SWITCH only)
- sw_wr
REQ-007 css_fail, in any state, when sws or target is 2 or 3, SHALL set:
- sys_clk_sw<=0, target<=0, cnt<=0, hw<=1, state<=SWITCH.
- sw_err<=1.
REQ-008 css_fail SHALL be ignored otherwise.
REQ-009 stop_exit, in any state, SHALL set:
- target = stopwuck ? 1 : 0, loaded into both sys_clk_sw and target.
- cnt<=0, hw<=1, state<=SWITCH.
- The src_rdy check SHALL be bypassed.
REQ-010 sw_wr in IDLE, with sw_req==sws, SHALL pulse sw_done the next cycle and make no state change.
REQ-011 sw_wr in IDLE, with src_rdy[sw_req]==0, SHALL pulse sw_err and leave sys_clk_sw/sws unchanged.
REQ-012 sw_wr in IDLE, otherwise, SHALL set:
- target<=sw_req, sys_clk_sw<=sw_req (visible one cycle after the sw_wr edge).
- cnt<=0, hw<=0, state<=SWITCH.
REQ-013 sw_wr in SWITCH SHALL be ignored and SHALL pulse sw_err.
REQ-014 In SWITCH with hw==0, src_rdy[target]==0 SHALL revert:
- sys_clk_sw<=sws, target<=sws, cnt<=0, hw<=1.
- sw_err pulse.
REQ-015 In SWITCH, cnt SHALL increment by 1 per cycle.
REQ-016 In SWITCH, at cnt==SETTLE_CYCLES-1 the block SHALL:
- set sws<=target and state<=IDLE;
- pulse sw_done only if hw==0.
REQ-017 sws SHALL update exactly SETTLE_CYCLES cycles after sys_clk_sw changes, unless a higher-priority event restarts the count.
REQ-018 sw_done and sw_err SHALL never be asserted in the same cycle; sw_err SHALL take priority.
REQ-019 cnt SHALL NOT wrap; it SHALL be reloaded to 0 on every (re)entry to SWITCH.
REQ-020 A restart while in SWITCH (REQ-007, REQ-009 or REQ-014) SHALL discard the old target without updating sws.

Reset
REQ-021 On sys_rst_n low, asynchronously:
- sys_clk_sw=0, sws=0, target=0, cnt=0, hw=0, state=IDLE.
- sw_busy=0, sw_done=0, sw_err=0.
REQ-022 Reset asserted mid-SWITCH SHALL abandon the switch and return the select to HSI immediately.
REQ-023 The block SHALL leave reset on the first hsi_clk edge after sys_rst_n rises.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Normal switch: reset, src_rdy=4'b1111, sw_req=3, sw_wr pulse -> sys_clk_sw=3 next cycle; sw_busy=1 for 4 cycles; sws=3 with one sw_done pulse.
- Not ready: src_rdy=4'b0011, sw_req=2, sw_wr -> single sw_err pulse; sys_clk_sw=0, sws=0, sw_busy=0.
- Ready drop: switch to 2 started, src_rdy[2] cleared 2 cycles later -> sys_clk_sw back to 0, sw_err pulse, sws stays 0 after 4 more cycles, no sw_done.
- CSS: sws=2, css_fail pulse -> sys_clk_sw=0, sw_err, sws=0 after 4 cycles; css_fail with sws=1 -> no effect.
- Stop exit with stopwuck=1 during a switch to 3 -> sys_clk_sw=1, sws=1 after 4 cycles, no sw_done; same edge as sw_wr -> stop_exit wins.
- Reset mid-SWITCH (cnt=2) -> all outputs zero immediately; SETTLE_CYCLES=1 -> sws updates one cycle after sys_clk_sw.

Source files
------------

// File: rtl/rcc_sys_clk_sw_ctrl.sv
// System clock switch controller.
// Picks the system clock source (HSI, CSI, HSE or PLL1_P) and drives a
// glitch-free switch. The reported source (sws) only changes after the
// switch has had SETTLE_CYCLES hsi_clk cycles to complete. A clock-security
// failure or a Stop-mode exit can force the select to a safe source. A
// software switch whose target loses its ready flag reverts to the source
// currently in use.
module rcc_sys_clk_sw_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic       hsi_clk,
    input  logic       sys_rst_n,
    input  logic [1:0] sw_req,
    input  logic       sw_wr,
    input  logic [3:0] src_rdy,
    input  logic       stop_exit,
    input  logic       stopwuck,
    input  logic       css_fail,
    output logic [1:0] sys_clk_sw,
    output logic [1:0] sws,
    output logic       sw_busy,
    output logic       sw_done,
    output logic       sw_err
);

    // Source codes; the code is also the bit index into src_rdy.
    localparam logic [1:0] SRC_HSI = 2'd0;

    // Last count value of a switch; the switch completes on this cycle.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    typedef enum logic {
        IDLE   = 1'b0,
        SWITCH = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] target;
    logic [3:0] cnt;
    logic       hw;

    // HSE (2) and PLL1_P (3) both depend on the HSE oscillator, so a
    // security failure matters only when either the source in use or the
    // source being switched to has bit 1 set.
    logic       css_hit;
    logic [1:0] wake_src;

    assign css_hit  = css_fail && (sws[1] || target[1]);
    assign wake_src = {1'b0, stopwuck};

    // sw_busy is a decode of the state flop, so it carries no input path.
    assign sw_busy  = (state == SWITCH);

    // Prioritised switch FSM: CSS, Stop exit, ready drop, then software.
    // NOTE: all state here uses non-blocking assignments so every branch
    // sees the pre-edge values of sws, target and cnt, as the flops do.
    always_ff @(posedge hsi_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state      <= IDLE;
            target     <= SRC_HSI;
            cnt        <= '0;
            hw         <= 1'b0;
            sys_clk_sw <= SRC_HSI;
            sws        <= SRC_HSI;
            sw_done    <= 1'b0;
            sw_err     <= 1'b0;
        end else begin
            sw_done <= 1'b0;
            sw_err  <= 1'b0;

            if (css_hit) begin
                // Fall back to HSI; any switch in flight is discarded.
                sys_clk_sw <= SRC_HSI;
                target     <= SRC_HSI;
                cnt        <= '0;
                hw         <= 1'b1;
                state      <= SWITCH;
                sw_err     <= 1'b1;
            end else if (stop_exit) begin
                // Wake-up clock is always running, so no ready check.
                sys_clk_sw <= wake_src;
                target     <= wake_src;
                cnt        <= '0;
                hw         <= 1'b1;
                state      <= SWITCH;
            end else if (state == SWITCH) begin
                if (!hw && !src_rdy[target]) begin
                    // Target vanished mid-switch: go back to the source in use.
                    sys_clk_sw <= sws;
                    target     <= sws;
                    cnt        <= '0;
                    hw         <= 1'b1;
                    sw_err     <= 1'b1;
                end else begin
                    // A write during a switch is refused; the error pulse
                    // also suppresses a coincident completion pulse.
                    if (sw_wr) begin
                        sw_err <= 1'b1;
                    end
                    if (cnt == CNT_LAST) begin
                        sws     <= target;
                        state   <= IDLE;
                        sw_done <= !hw && !sw_wr;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
            end else if (sw_wr) begin
                if (sw_req == sws) begin
                    // Already running from the requested source.
                    sw_done <= 1'b1;
                end else if (!src_rdy[sw_req]) begin
                    sw_err <= 1'b1;
                end else begin
                    sys_clk_sw <= sw_req;
                    target     <= sw_req;
                    cnt        <= '0;
                    hw         <= 1'b0;
                    state      <= SWITCH;
                end
            end
        end
    end

endmodule
